// File: rtl/branch_cond_unit.sv
// Pipelined MIPS branch-condition evaluator with valid/ready handshake,
// synchronous flush and a saturating taken-branch counter.
module branch_cond_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned PIPE_STAGES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mode,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic             a_zero,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef enum logic [2:0] {
    ModeEq    = 3'b000,
    ModeNe    = 3'b001,
    ModeLez   = 3'b010,
    ModeGtz   = 3'b011,
    ModeLtz   = 3'b100,
    ModeGez   = 3'b101,
    ModeZero  = 3'b110,
    ModeNever = 3'b111
  } mode_e;

  // Resolve the branch condition from the pre-computed compare flags.
  function automatic logic cond_eval(mode_e m, logic eq, logic zero, logic sign);
    logic r;
    r = 1'b0;
    case (m)
      ModeEq:    r = eq;
      ModeNe:    r = !eq;
      ModeLez:   r = sign || zero;
      ModeGtz:   r = !sign && !zero;
      ModeLtz:   r = sign;
      ModeGez:   r = !sign;
      ModeZero:  r = zero;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

  // Operand flags computed straight from the inputs.
  logic eq_c, zero_c, sign_c;
  assign eq_c   = (a == b);
  assign zero_c = ~|a;
  assign sign_c = a[WIDTH-1];

  // Output (last) stage state.
  logic             out_valid_q;
  logic             taken_q;
  logic             a_zero_q;
  logic [CNT_W-1:0] taken_cnt_q;

  // Feed into the last stage from whichever stage precedes it.
  logic feed_valid, feed_taken, feed_zero;
  logic last_free, out_xfer, last_load;

  assign out_xfer  = out_valid_q && out_ready;
  // Last stage can take new data when empty or emptying this cycle.
  assign last_free = !out_valid_q || out_ready;
  assign last_load = last_free && feed_valid && !flush;

  if (PIPE_STAGES == 2) begin : g_two_stage
    logic             s1_valid_q;
    logic             s1_eq_q;
    logic             s1_zero_q;
    logic             s1_sign_q;
    logic [2:0]       s1_mode_q;
    logic             s1_load;

    assign in_ready   = !s1_valid_q || last_free;
    assign s1_load    = in_valid && in_ready && !flush;
    assign feed_valid = s1_valid_q;
    assign feed_taken = cond_eval(mode_e'(s1_mode_q), s1_eq_q, s1_zero_q, s1_sign_q);
    assign feed_zero  = s1_zero_q;

    // Stage 1: capture compare flags and mode on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid_q <= 1'b0;
        s1_eq_q    <= 1'b0;
        s1_zero_q  <= 1'b0;
        s1_sign_q  <= 1'b0;
        s1_mode_q  <= 3'b000;
      end else begin
        if (flush) begin
          s1_valid_q <= 1'b0;
        end else if (in_ready) begin
          s1_valid_q <= in_valid;
        end
        if (s1_load) begin
          s1_eq_q   <= eq_c;
          s1_zero_q <= zero_c;
          s1_sign_q <= sign_c;
          s1_mode_q <= mode;
        end
      end
    end
  end else begin : g_one_stage
    assign in_ready   = last_free;
    assign feed_valid = in_valid;
    assign feed_taken = cond_eval(mode_e'(mode), eq_c, zero_c, sign_c);
    assign feed_zero  = zero_c;
  end

  // Output stage: data held while stalled; flush drops the valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      a_zero_q    <= 1'b0;
    end else begin
      if (flush) begin
        out_valid_q <= 1'b0;
      end else if (last_free) begin
        out_valid_q <= feed_valid;
      end
      if (last_load) begin
        taken_q  <= feed_taken;
        a_zero_q <= feed_zero;
      end
    end
  end

  // Taken counter: clear wins over increment, saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q <= '0;
    end else if (cnt_clr) begin
      taken_cnt_q <= '0;
    end else if (out_xfer && taken_q && (taken_cnt_q != '1)) begin
      taken_cnt_q <= taken_cnt_q + 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign taken     = taken_q;
  assign a_zero    = a_zero_q;
  assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Bench for branch_cond_unit: three configurations driven side by side,
// checked against a queue-based behavioural model.
module tb_branch_cond_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance 0: W32/P1/C16, 1: W32/P2/C2, 2: W8/P1/C3.
  logic        in_valid [3];
  logic        in_ready [3];
  logic [31:0] a        [3];
  logic [31:0] b        [3];
  logic [2:0]  mode     [3];
  logic        flush    [3];
  logic        out_valid[3];
  logic        out_ready[3];
  logic        taken    [3];
  logic        a_zero   [3];
  logic        cnt_clr  [3];
  logic [15:0] cnt0;
  logic [1:0]  cnt1;
  logic [2:0]  cnt2;

  int width  [3] = '{32, 32, 8};
  int cnt_max[3] = '{65535, 3, 7};

  branch_cond_unit #(.WIDTH(32), .PIPE_STAGES(1), .CNT_W(16)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .mode(mode[0]), .flush(flush[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .taken(taken[0]), .a_zero(a_zero[0]),
    .cnt_clr(cnt_clr[0]), .taken_cnt(cnt0));

  branch_cond_unit #(.WIDTH(32), .PIPE_STAGES(2), .CNT_W(2)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1]), .b(b[1]), .mode(mode[1]), .flush(flush[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .taken(taken[1]), .a_zero(a_zero[1]),
    .cnt_clr(cnt_clr[1]), .taken_cnt(cnt1));

  branch_cond_unit #(.WIDTH(8), .PIPE_STAGES(1), .CNT_W(3)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2][7:0]), .b(b[2][7:0]), .mode(mode[2]), .flush(flush[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .taken(taken[2]),
    .a_zero(a_zero[2]), .cnt_clr(cnt_clr[2]), .taken_cnt(cnt2));

  typedef struct {
    int   id;
    logic t;
    logic z;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  m;
    logic        t;
    logic        z;
  } vec_t;

  exp_t q[$];
  int   mcnt[3];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic logic [15:0] get_cnt(int k);
    if (k == 0) return cnt0;
    if (k == 1) return 16'(cnt1);
    return 16'(cnt2);
  endfunction

  // Reference: signed arithmetic on the operand at the instance width.
  function automatic exp_t ref_of(int k, logic [31:0] av, logic [31:0] bv, logic [2:0] m);
    exp_t e;
    int   sa;
    logic eq;
    if (width[k] == 8) begin
      sa = $signed(av[7:0]);
      eq = (av[7:0] == bv[7:0]);
    end else begin
      sa = $signed(av);
      eq = (av == bv);
    end
    e.id = k;
    e.z  = (sa == 0);
    case (m)
      3'd0:    e.t = eq;
      3'd1:    e.t = !eq;
      3'd2:    e.t = (sa <= 0);
      3'd3:    e.t = (sa > 0);
      3'd4:    e.t = (sa < 0);
      3'd5:    e.t = (sa >= 0);
      3'd6:    e.t = (sa == 0);
      default: e.t = 1'b0;
    endcase
    return e;
  endfunction

  function automatic int find_id(int k);
    for (int i = 0; i < q.size(); i++) if (q[i].id == k) return i;
    return -1;
  endfunction

  function automatic int count_id(int k);
    int n = 0;
    for (int i = 0; i < q.size(); i++) if (q[i].id == k) n++;
    return n;
  endfunction

  // One clock: check presented outputs, update model, check counters.
  task automatic step();
    int idx;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (out_valid[k]) begin
        idx = find_id(k);
        chk($sformatf("out_expected_d%0d", k), 32'(idx >= 0), 32'd1);
        if (idx >= 0) begin
          chk($sformatf("taken_d%0d", k), 32'(taken[k]), 32'(q[idx].t));
          chk($sformatf("a_zero_d%0d", k), 32'(a_zero[k]), 32'(q[idx].z));
          if (out_ready[k]) begin
            if (q[idx].t && mcnt[k] < cnt_max[k]) mcnt[k]++;
            q.delete(idx);
          end
        end
      end
      if (cnt_clr[k]) mcnt[k] = 0;
      if (flush[k]) begin
        for (int i = q.size() - 1; i >= 0; i--) if (q[i].id == k) q.delete(i);
      end else if (in_valid[k] && in_ready[k]) begin
        q.push_back(ref_of(k, a[k], b[k], mode[k]));
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("taken_cnt_d%0d", k), 32'(get_cnt(k)), mcnt[k]);
    @(negedge clk);
  endtask

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b1; flush[k] = 1'b0; cnt_clr[k] = 1'b0;
      a[k] = '0; b[k] = '0; mode[k] = 3'd7;
    end
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h7FFF_FFFF;
      5: return 32'h80;
      6: return 32'h7F;
      default: return $urandom;
    endcase
  endfunction

  vec_t modes_v[12] = '{
    '{32'h1234, 32'h1234, 3'd0, 1'b1, 1'b0}, '{32'h1234, 32'h1234, 3'd1, 1'b0, 1'b0},
    '{32'h8000_0000, 32'h0, 3'd4, 1'b1, 1'b0}, '{32'h8000_0000, 32'h0, 3'd2, 1'b1, 1'b0},
    '{32'h8000_0000, 32'h0, 3'd5, 1'b0, 1'b0}, '{32'h8000_0000, 32'h0, 3'd3, 1'b0, 1'b0},
    '{32'h0, 32'h55, 3'd6, 1'b1, 1'b1}, '{32'h0, 32'h55, 3'd5, 1'b1, 1'b1},
    '{32'h0, 32'h55, 3'd2, 1'b1, 1'b1}, '{32'h0, 32'h55, 3'd3, 1'b0, 1'b1},
    '{32'h5, 32'h5, 3'd7, 1'b0, 1'b0}, '{32'h0, 32'h0, 3'd7, 1'b0, 1'b1}
  };
  vec_t width_v[3] = '{
    '{32'h7F, 32'h0, 3'd3, 1'b1, 1'b0}, '{32'h80, 32'h0, 3'd4, 1'b1, 1'b0},
    '{32'h00, 32'h00, 3'd0, 1'b1, 1'b1}
  };
  vec_t bp_v[5] = '{
    '{32'h0, 32'h0, 3'd0, 1'b1, 1'b1}, '{32'h1, 32'h2, 3'd0, 1'b0, 1'b0},
    '{32'h0, 32'h0, 3'd3, 1'b0, 1'b1}, '{32'h3, 32'h0, 3'd3, 1'b1, 1'b0},
    '{32'hFFFF_FFFF, 32'h0, 3'd4, 1'b1, 1'b0}
  };
  logic bp_rdy[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  int   cnt_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    int   i;
    int   n_out;
    logic acc;
    logic xfer;

    idle_all();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) mcnt[k] = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_out_valid_d%0d", k), 32'(out_valid[k]), 32'd0);
      chk($sformatf("rst_in_ready_d%0d", k), 32'(in_ready[k]), 32'd1);
      chk($sformatf("rst_taken_d%0d", k), 32'(taken[k]), 32'd0);
      chk($sformatf("rst_a_zero_d%0d", k), 32'(a_zero[k]), 32'd0);
      chk($sformatf("rst_cnt_d%0d", k), 32'(get_cnt(k)), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Every mode on the single-stage 32-bit instance, one per cycle.
    foreach (modes_v[j]) begin
      in_valid[0] = 1'b1; a[0] = modes_v[j].a; b[0] = modes_v[j].b; mode[0] = modes_v[j].m;
      step();
      chk($sformatf("mode_valid_%0d", j), 32'(out_valid[0]), 32'd1);
      chk($sformatf("mode_taken_%0d", j), 32'(taken[0]), 32'(modes_v[j].t));
      chk($sformatf("mode_azero_%0d", j), 32'(a_zero[0]), 32'(modes_v[j].z));
    end
    in_valid[0] = 1'b0;
    step();

    // 8-bit operand width boundaries.
    foreach (width_v[j]) begin
      in_valid[2] = 1'b1; a[2] = width_v[j].a; b[2] = width_v[j].b; mode[2] = width_v[j].m;
      step();
      chk($sformatf("w8_taken_%0d", j), 32'(taken[2]), 32'(width_v[j].t));
      chk($sformatf("w8_azero_%0d", j), 32'(a_zero[2]), 32'(width_v[j].z));
    end
    in_valid[2] = 1'b0;
    step();

    // Back-pressure on the two-stage instance.
    i = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      out_ready[1] = (cyc >= 4);
      in_valid[1]  = (i < 5);
      if (i < 5) begin
        a[1] = bp_v[i].a; b[1] = bp_v[i].b; mode[1] = bp_v[i].m;
      end
      #1;
      if (cyc < 4) chk($sformatf("bp_in_ready_c%0d", cyc), 32'(in_ready[1]), 32'(bp_rdy[cyc]));
      if (cyc == 1) chk("bp_latency_early", 32'(out_valid[1]), 32'd0);
      if (cyc == 2) chk("bp_latency_two", 32'(out_valid[1]), 32'd1);
      acc = in_valid[1] && in_ready[1];
      step();
      if (acc) i++;
    end
    chk("bp_accepted", i, 5);
    chk("bp_drained", count_id(1), 0);
    idle_all();

    // Flush with two entries in flight plus an offered input.
    out_ready[1] = 1'b0;
    in_valid[1] = 1'b1; a[1] = 32'h7; b[1] = 32'h7; mode[1] = 3'd0;
    step();
    a[1] = 32'h0; mode[1] = 3'd6;
    step();
    chk("fl_inflight", count_id(1), 2);
    flush[1] = 1'b1; a[1] = 32'h9; mode[1] = 3'd1;
    step();
    flush[1] = 1'b0; in_valid[1] = 1'b0; out_ready[1] = 1'b1;
    #1;
    chk("fl_out_valid_next", 32'(out_valid[1]), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("fl_quiet_c%0d", c), 32'(out_valid[1]), 32'd0);
    end

    // Saturating counter, CNT_W=2.
    cnt_clr[1] = 1'b1;
    step();
    cnt_clr[1] = 1'b0;
    i = 0;
    n_out = 0;
    for (int cyc = 0; cyc < 12 && n_out < 5; cyc++) begin
      in_valid[1] = (i < 5);
      a[1] = 32'(cyc); b[1] = 32'(cyc); mode[1] = 3'd0;
      #1;
      acc  = in_valid[1] && in_ready[1];
      xfer = out_valid[1] && out_ready[1];
      step();
      if (acc) i++;
      if (xfer) begin
        chk($sformatf("cnt_sat_%0d", n_out), 32'(cnt1), cnt_exp[n_out]);
        n_out++;
      end
    end
    chk("cnt_transfers", n_out, 5);
    in_valid[1] = 1'b1; out_ready[1] = 1'b0; a[1] = 32'h3; b[1] = 32'h3; mode[1] = 3'd0;
    step();
    in_valid[1] = 1'b0;
    step();
    chk("clr_setup_valid", 32'(out_valid[1]), 32'd1);
    out_ready[1] = 1'b1; cnt_clr[1] = 1'b1;
    step();
    chk("clr_priority", 32'(cnt1), 32'd0);
    idle_all();

    // Randomised traffic on all instances.
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        in_valid[k]  = ($urandom_range(0, 9) < 7);
        out_ready[k] = ($urandom_range(0, 9) < 7);
        flush[k]     = ($urandom_range(0, 39) == 0);
        cnt_clr[k]   = ($urandom_range(0, 59) == 0);
        a[k]         = rand_op();
        b[k]         = ($urandom_range(0, 1) == 0) ? a[k] : rand_op();
        mode[k]      = 3'($urandom_range(0, 7));
      end
      step();
    end
    idle_all();
    for (int c = 0; c < 10 && q.size() > 0; c++) step();
    chk("rand_drained", q.size(), 0);

    // Asynchronous reset with two entries in flight.
    out_ready[1] = 1'b0; in_valid[1] = 1'b1; a[1] = 32'h1; b[1] = 32'h1; mode[1] = 3'd0;
    step();
    step();
    in_valid[1] = 1'b0;
    chk("mid_inflight", count_id(1), 2);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("mid_rst_out_valid_d%0d", k), 32'(out_valid[k]), 32'd0);
      chk($sformatf("mid_rst_in_ready_d%0d", k), 32'(in_ready[k]), 32'd1);
      chk($sformatf("mid_rst_cnt_d%0d", k), 32'(get_cnt(k)), 32'd0);
      mcnt[k] = 0;
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle_all();
    step();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
